// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU and LSU write-back queues
// share one registered RF write port, LSU first with ALU starvation guard.

// Per-source write-back queue with occupancy-derived pending mask.
module rf_wb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_valid,
    input  logic [4:0]  push_rd,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        ready,
    output logic        empty,
    output logic [4:0]  head_rd,
    output logic [31:0] head_data,
    output logic [31:0] pend_mask
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [4:0]    rd_mem_d   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   data_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          do_pop;

    assign ready     = (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    // x0 writes complete the handshake but are never stored
    assign push      = push_valid && ready && (push_rd != 5'd0);
    assign do_pop    = pop && !empty;
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            rd_mem_d[wr_ptr_q]   = push_rd;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Destination bits of every occupied slot, walked from the head
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                pend_mask[rd_mem_q[rd_ptr_q + AW'(i)]] = 1'b1;
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic          alu_empty, lsu_empty;
    logic [4:0]    alu_head_rd, lsu_head_rd;
    logic [31:0]   alu_head_data, lsu_head_data;
    logic [31:0]   alu_pend, lsu_pend;
    logic          grant_alu, grant_lsu;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]   wb_mask;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (alu_valid),
        .push_rd    (alu_rd),
        .push_data  (alu_data),
        .pop        (grant_alu),
        .ready      (alu_ready),
        .empty      (alu_empty),
        .head_rd    (alu_head_rd),
        .head_data  (alu_head_data),
        .pend_mask  (alu_pend)
    );

    rf_wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (lsu_valid),
        .push_rd    (lsu_rd),
        .push_data  (lsu_data),
        .pop        (grant_lsu),
        .ready      (lsu_ready),
        .empty      (lsu_empty),
        .head_rd    (lsu_head_rd),
        .head_data  (lsu_head_data),
        .pend_mask  (lsu_pend)
    );

    // LSU wins contention unless the ALU has lost STARVE_MAX times in a row
    always_comb begin
        grant_lsu = 1'b0;
        grant_alu = 1'b0;
        if (!lsu_empty && !alu_empty) begin
            if (starve_q == SW'(STARVE_MAX)) begin
                grant_alu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else if (!lsu_empty) begin
            grant_lsu = 1'b1;
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end
    end

    // Count consecutive grants lost by a waiting ALU head
    always_comb begin
        starve_d = starve_q;
        if (alu_empty || grant_alu) begin
            starve_d = '0;
        end else if (grant_lsu && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Load the write port from the granted head; address/data hold otherwise
    always_comb begin
        rf_we_d    = grant_alu || grant_lsu;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_lsu) begin
            rf_waddr_d = lsu_head_rd;
            rf_wdata_d = lsu_head_data;
        end else if (grant_alu) begin
            rf_waddr_d = alu_head_rd;
            rf_wdata_d = alu_head_data;
        end
    end

    // Arbiter and write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Hazard mask: queued destinations plus the write on the port now
    always_comb begin
        wb_mask = '0;
        if (rf_we_q) begin
            wb_mask[rf_waddr_q] = 1'b1;
        end
        pending_mask = (alu_pend | lsu_pend | wb_mask) & ~32'd1;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: queue-level reference model,
// randomized and directed write-back streams from both sources.
module tb_rf_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] data;
    } stim_t;

    stim_t       a_stim[$];
    stim_t       l_stim[$];
    wr_t         aq[$];
    wr_t         lq[$];
    wr_t         sb[$];
    bit          src_log[$];
    int          starve = 0;
    bit          m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          a_fire = 0;
    bit          l_fire = 0;

    int          g;
    bit          a_acc, l_acc;
    wr_t         gw;
    wr_t         mw;
    stim_t       si;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (aq[i]) m[aq[i].rd] = 1'b1;
        foreach (lq[i]) m[lq[i].rd] = 1'b1;
        if (m_we) m[m_addr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Reference model: two queues, fixed LSU priority with a loss counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq.delete();
            lq.delete();
            sb.delete();
            starve = 0;
            m_we   = 0;
            m_addr = '0;
            m_data = '0;
        end else begin
            a_acc = alu_valid && (aq.size() < DEPTH);
            l_acc = lsu_valid && (lq.size() < DEPTH);
            if (aq.size() != 0 && lq.size() != 0)
                g = (starve == STARVE_MAX) ? 1 : 2;
            else if (lq.size() != 0) g = 2;
            else if (aq.size() != 0) g = 1;
            else g = 0;
            if (aq.size() == 0 || g == 1) starve = 0;
            else if (starve < STARVE_MAX) starve++;
            m_we = (g != 0);
            if (g == 1) gw = aq.pop_front();
            else if (g == 2) gw = lq.pop_front();
            if (m_we) begin
                m_addr = gw.rd;
                m_data = gw.data;
                sb.push_back(gw);
            end
            if (a_acc && alu_rd != 5'd0) aq.push_back('{alu_rd, alu_data});
            if (l_acc && lsu_rd != 5'd0) lq.push_back('{lsu_rd, lsu_data});
        end
    end

    // Monitor: compare port activity and status against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, aq.size() < DEPTH});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, lq.size() < DEPTH});
            chk("pending_mask", pending_mask, model_mask());
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            if (rf_we) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_write: got write rd=%0d with nothing expected",
                             rf_waddr);
                end else begin
                    mw = sb.pop_front();
                    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, mw.rd});
                    chk("rf_wdata", rf_wdata, mw.data);
                    src_log.push_back(rf_wdata[31]);
                end
            end
        end
    end

    // ALU driver: payload held until the handshake completes
    always @(negedge clk) begin
        if (!rst_n) begin
            alu_valid = 1'b0;
            a_fire    = 0;
        end else begin
            if (!alu_valid || a_fire) begin
                if (a_stim.size() != 0) begin
                    si = a_stim.pop_front();
                    alu_valid = si.v;
                    alu_rd    = si.rd;
                    alu_data  = si.data;
                end else begin
                    alu_valid = 1'b0;
                end
            end
            a_fire = alu_valid && alu_ready;
        end
    end

    // LSU driver
    always @(negedge clk) begin
        if (!rst_n) begin
            lsu_valid = 1'b0;
            l_fire    = 0;
        end else begin
            if (!lsu_valid || l_fire) begin
                if (l_stim.size() != 0) begin
                    stim_t s;
                    s = l_stim.pop_front();
                    lsu_valid = s.v;
                    lsu_rd    = s.rd;
                    lsu_data  = s.data;
                end else begin
                    lsu_valid = 1'b0;
                end
            end
            l_fire = lsu_valid && lsu_ready;
        end
    end

    task automatic drain(int budget);
        int k;
        k = 0;
        while (k < budget &&
               !(a_stim.size() == 0 && l_stim.size() == 0 &&
                 !alu_valid && !lsu_valid &&
                 aq.size() == 0 && lq.size() == 0 && !m_we)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", {31'd0, k < budget}, 32'd1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_rf_waddr"}, {27'd0, rf_waddr}, 32'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_mask"}, pending_mask, 32'd0);
        chk({tag, "_alu_ready"}, {31'd0, alu_ready}, 32'd1);
        chk({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd1);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single ALU write rd=5
        @(posedge clk);
        #1;
        a_stim.push_back('{1'b1, 5'd5, 32'hDEADBEEF});
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("single_mask_e", {31'd0, pending_mask[5]}, 32'd1);
        chk("single_we_e", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        #1;
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_addr", {27'd0, rf_waddr}, 32'd5);
        chk("single_data", rf_wdata, 32'hDEADBEEF);
        chk("single_mask_e1", {31'd0, pending_mask[5]}, 32'd1);
        @(negedge clk);
        #1;
        chk("single_we_done", {31'd0, rf_we}, 32'd0);
        chk("single_mask_done", {31'd0, pending_mask[5]}, 32'd0);
        drain(50);

        // x0 write is accepted and dropped
        @(posedge clk);
        #1;
        a_stim.push_back('{1'b1, 5'd0, 32'h1234});
        @(negedge clk);
        #1;
        chk("x0_handshake", {31'd0, alu_valid && alu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("x0_we", {31'd0, rf_we}, 32'd0);
            chk("x0_mask", pending_mask, 32'd0);
        end
        drain(50);

        // Contention: both sources stream, grant order L,L,L,L,A repeating
        @(posedge clk);
        #1;
        src_log.delete();
        for (int i = 0; i < 12; i++) begin
            a_stim.push_back('{1'b1, 5'(i + 1), {1'b0, 31'(i)}});
            l_stim.push_back('{1'b1, 5'(i + 13), {1'b1, 31'(i)}});
        end
        drain(400);
        chk("contend_log_len", {31'd0, src_log.size() >= 10}, 32'd1);
        if (src_log.size() >= 10) begin
            for (int k = 0; k < 10; k++)
                chk($sformatf("grant_seq_%0d", k), {31'd0, src_log[k]},
                    (k % 5 == 4) ? 32'd0 : 32'd1);
        end

        // Full ALU queue behind LSU traffic
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            a_stim.push_back('{1'b1, 5'(i + 20), 32'hA000_0000 + 32'(i)});
        for (int i = 0; i < 16; i++)
            l_stim.push_back('{1'b1, 5'(i + 1), 32'hB000_0000 + 32'(i)});
        @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        chk("full_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_5th_wait", {31'd0, alu_valid}, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("full_after_pop_ready", {31'd0, alu_ready}, 32'd1);
        chk("full_5th_still_wait", {31'd0, alu_valid}, 32'd1);
        drain(400);

        // Pointer wrap: 3*DEPTH writes per source
        @(posedge clk);
        #1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            a_stim.push_back('{1'b1, 5'(i + 1), $urandom});
            l_stim.push_back('{1'b1, 5'(i + 1), $urandom});
        end
        drain(400);

        // Reset mid-stream discards queued writes
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            a_stim.push_back('{1'b1, 5'(i + 1), $urandom});
            l_stim.push_back('{1'b1, 5'(i + 9), $urandom});
        end
        @(negedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        a_stim.delete();
        l_stim.delete();
        #1;
        chk_reset_outputs("mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_reset_we", {31'd0, rf_we}, 32'd0);
        end

        // Randomized traffic with bubbles and x0 destinations
        @(posedge clk);
        #1;
        for (int i = 0; i < 150; i++) begin
            a_stim.push_back('{($urandom_range(0, 3) != 0),
                               5'($urandom_range(0, 31)), $urandom});
            l_stim.push_back('{($urandom_range(0, 3) != 0),
                               5'($urandom_range(0, 31)), $urandom});
        end
        drain(3000);
        repeat (2) @(negedge clk);
        chk("sb_leftover", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
